eth_tx_ptp_ts_capture: RTL and testbench

Parametrised TX-path PTP timestamp capture block. It sits between the frame source and the MAC TX AXI-stream input. The data path is a zero-latency pass-through. On the first beat of each frame that requests a timestamp, it samples PTP time, adds a fixed egress-latency offset, and queues {timestamp, tag} in an internal FIFO. A valid/ready timestamp output port drains the FIFO. This generalises the fixed 64-bit/96-bit/16-bit-tag TX timestamp interface to arbitrary data width, both PTP formats, any tag width and buffered multi-frame operation.

---
 rtl/eth_ptp_pkg.sv | 54 +++++
 rtl/eth_ts_fifo.sv | 66 ++++++
 rtl/eth_tx_ptp_ts_capture.sv | 147 ++++++++++++++
 tb/tb_eth_tx_ptp_ts_capture.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_ptp_pkg.sv
// Shared PTP timestamp definitions for the Ethernet TX/RX timestamping blocks.
// Covers the ToD field layout and adding an egress/ingress offset in nanoseconds.
package eth_ptp_pkg;

  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  localparam int TOD_FNS_LSB = 0;
  localparam int TOD_FNS_W   = 16;
  localparam int TOD_NS_LSB  = 16;
  localparam int TOD_NS_W    = 32;
  localparam int TOD_SEC_LSB = 48;
  localparam int TOD_SEC_W   = 48;
  localparam int TS_EXT_W    = 96;

  typedef enum logic {
    PTP_FMT_64  = 1'b0,
    PTP_FMT_TOD = 1'b1
  } ptp_fmt_e;

  // ToD carries nanoseconds into seconds; the flat format adds ns above the 16 fractional bits.
  function automatic logic [TS_EXT_W-1:0] ptp_ts_add_ns(
    input logic [TS_EXT_W-1:0] ts,
    input logic [31:0]         ns,
    input ptp_fmt_e            fmt
  );
    logic [TOD_NS_W:0]    ns_sum;
    logic [TOD_SEC_W-1:0] sec;
    logic [63:0]          flat;
    logic [TS_EXT_W-1:0]  res;
    ns_sum = '0;
    sec    = '0;
    flat   = '0;
    res    = '0;
    case (fmt)
      PTP_FMT_TOD: begin
        sec    = ts[TOD_SEC_LSB +: TOD_SEC_W];
        ns_sum = {1'b0, ts[TOD_NS_LSB +: TOD_NS_W]} + {1'b0, ns};
        if (ns_sum >= {1'b0, NS_PER_SEC}) begin
          ns_sum = ns_sum - {1'b0, NS_PER_SEC};
          sec    = sec + 48'd1;
        end else begin
          sec    = sec;
        end
        res = {sec, ns_sum[TOD_NS_W-1:0], ts[TOD_FNS_LSB +: TOD_FNS_W]};
      end
      default: begin
        flat = ts[63:0] + {16'd0, ns, 16'd0};
        res  = {32'd0, flat};
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/eth_ts_fifo.sv
// First-word-fall-through FIFO for timestamp records, shared by TX and RX capture.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module eth_ts_fifo #(
  parameter int WIDTH = 112,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  // Head is masked when empty so a freshly reset FIFO presents all-zero data.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/eth_tx_ptp_ts_capture.sv
// TX PTP timestamp capture: zero-latency AXI-stream pass-through that timestamps
// the first beat of requesting frames, adds the egress offset and buffers {tag, ts}.
module eth_tx_ptp_ts_capture
  import eth_ptp_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int PTP_TS_FMT_TOD = 1,
  parameter int PTP_TS_WIDTH   = (PTP_TS_FMT_TOD != 0) ? 96 : 64,
  parameter int TAG_WIDTH      = 16,
  parameter int TS_OFFSET_NS   = 0,
  parameter int FIFO_DEPTH     = 4,
  parameter int USER_WIDTH     = TAG_WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  input  logic [PTP_TS_WIDTH-1:0] ptp_time,
  output logic [PTP_TS_WIDTH-1:0] m_ts,
  output logic [TAG_WIDTH-1:0]    m_ts_tag,
  output logic                    m_ts_valid,
  input  logic                    m_ts_ready,
  output logic [15:0]             ts_drop_count
);

  localparam ptp_fmt_e TS_FMT = (PTP_TS_FMT_TOD != 0) ? PTP_FMT_TOD : PTP_FMT_64;
  localparam int       REC_W  = TAG_WIDTH + PTP_TS_WIDTH;

  logic                    in_frame_q, in_frame_d;
  logic                    cap_valid_q, cap_valid_d;
  logic [PTP_TS_WIDTH-1:0] cap_ts_q, cap_ts_d;
  logic [TAG_WIDTH-1:0]    cap_tag_q, cap_tag_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;

  logic                    hs_s;
  logic                    sof_s;
  logic                    ts_req_s;
  logic [TAG_WIDTH-1:0]    tag_s;
  logic [TS_EXT_W-1:0]     cap_ext_s;
  logic [TS_EXT_W-1:0]     ts_sum_s;
  logic [REC_W-1:0]        fifo_wdata_s;
  logic [REC_W-1:0]        fifo_rdata_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    ts_pop_s;
  logic                    ts_drop_s;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tuser  = s_axis_tuser[0];
  assign s_axis_tready = m_axis_tready;

  assign hs_s     = s_axis_tvalid && m_axis_tready;
  assign sof_s    = hs_s && !in_frame_q;
  assign ts_req_s = s_axis_tuser[1];
  assign tag_s    = s_axis_tuser[2 +: TAG_WIDTH];

  // Frame tracking and capture stage: ptp_time is sampled on the SOF handshake itself.
  always_comb begin
    in_frame_d  = in_frame_q;
    cap_valid_d = 1'b0;
    cap_ts_d    = cap_ts_q;
    cap_tag_d   = cap_tag_q;
    if (hs_s) begin
      in_frame_d = !s_axis_tlast;
    end else begin
      in_frame_d = in_frame_q;
    end
    if (sof_s && ts_req_s) begin
      cap_valid_d = 1'b1;
      cap_ts_d    = ptp_time;
      cap_tag_d   = tag_s;
    end else begin
      cap_valid_d = 1'b0;
    end
  end

  always_comb begin
    cap_ext_s                     = '0;
    cap_ext_s[PTP_TS_WIDTH-1:0]   = cap_ts_q;
  end

  assign ts_sum_s     = ptp_ts_add_ns(cap_ext_s, 32'(TS_OFFSET_NS), TS_FMT);
  assign fifo_wdata_s = {cap_tag_q, ts_sum_s[PTP_TS_WIDTH-1:0]};
  assign ts_pop_s     = m_ts_valid && m_ts_ready;
  assign ts_drop_s    = cap_valid_q && fifo_full_s && !ts_pop_s;

  // Drop counter saturates so a stuck consumer never wraps it back to a small value.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ts_drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_frame_q  <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_ts_q    <= '0;
      cap_tag_q   <= '0;
      drop_cnt_q  <= 16'd0;
    end else begin
      in_frame_q  <= in_frame_d;
      cap_valid_q <= cap_valid_d;
      cap_ts_q    <= cap_ts_d;
      cap_tag_q   <= cap_tag_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  eth_ts_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_ts_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cap_valid_q),
    .push_data_i (fifo_wdata_s),
    .pop_i       (ts_pop_s),
    .pop_data_o  (fifo_rdata_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     ()
  );

  assign m_ts_valid    = !fifo_empty_s;
  assign m_ts          = fifo_rdata_s[PTP_TS_WIDTH-1:0];
  assign m_ts_tag      = fifo_rdata_s[PTP_TS_WIDTH +: TAG_WIDTH];
  assign ts_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_eth_tx_ptp_ts_capture.sv
// Bench for eth_tx_ptp_ts_capture: a ToD instance (offset 20 ns) driven through
// vector tables and a scoreboard, plus a 64-bit instance (offset 1 ns) for wrap.
module tb_eth_tx_ptp_ts_capture;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ToD instance signals
  logic [63:0]  s_tdata = '0;
  logic [7:0]   s_tkeep = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic [17:0]  s_tuser = '0;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tuser;
  logic         m_tready = 1'b1;
  logic [95:0]  ptp_a = '0;
  logic [95:0]  m_ts;
  logic [15:0]  m_ts_tag;
  logic         m_ts_valid;
  logic         m_ts_ready = 1'b0;
  logic [15:0]  drop_a;

  // 64-bit instance signals
  logic [31:0]  b_tdata = '0;
  logic [3:0]   b_tkeep = '0;
  logic         b_tvalid = 1'b0;
  logic         b_tready;
  logic         b_tlast = 1'b0;
  logic [17:0]  b_tuser = '0;
  logic [31:0]  bm_tdata;
  logic [3:0]   bm_tkeep;
  logic         bm_tvalid;
  logic         bm_tlast;
  logic         bm_tuser;
  logic [63:0]  ptp_b = '0;
  logic [63:0]  b_ts;
  logic [15:0]  b_ts_tag;
  logic         b_ts_valid;
  logic         b_ts_ready = 1'b0;
  logic [15:0]  drop_b;

  eth_tx_ptp_ts_capture #(
    .DATA_WIDTH(64), .PTP_TS_FMT_TOD(1), .TAG_WIDTH(16),
    .TS_OFFSET_NS(20), .FIFO_DEPTH(4)
  ) u_tod (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .ptp_time(ptp_a), .m_ts(m_ts), .m_ts_tag(m_ts_tag), .m_ts_valid(m_ts_valid),
    .m_ts_ready(m_ts_ready), .ts_drop_count(drop_a)
  );

  eth_tx_ptp_ts_capture #(
    .DATA_WIDTH(32), .PTP_TS_FMT_TOD(0), .TAG_WIDTH(16),
    .TS_OFFSET_NS(1), .FIFO_DEPTH(4)
  ) u_b64 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
    .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .s_axis_tuser(b_tuser),
    .m_axis_tdata(bm_tdata), .m_axis_tkeep(bm_tkeep), .m_axis_tvalid(bm_tvalid),
    .m_axis_tlast(bm_tlast), .m_axis_tuser(bm_tuser), .m_axis_tready(1'b1),
    .ptp_time(ptp_b), .m_ts(b_ts), .m_ts_tag(b_ts_tag), .m_ts_valid(b_ts_valid),
    .m_ts_ready(b_ts_ready), .ts_drop_count(drop_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [111:0] exp_q [$];

  typedef struct {
    logic        ts_req;
    logic [15:0] tag;
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] fns;
    logic [47:0] exp_sec;
    logic [31:0] exp_ns;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [95:0] tod(input logic [47:0] sec, input logic [31:0] ns,
                                      input logic [15:0] fns);
    return {sec, ns, fns};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [63:0] data, input logic [7:0] keep, input logic last,
                            input logic tsreq, input logic [15:0] tag, input logic err,
                            input logic [95:0] ptp);
    s_tdata  = data;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tuser  = {tag, tsreq, err};
    s_tvalid = 1'b1;
    ptp_a    = ptp;
    #1;
    check("passthru", {m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser, s_tready},
          {data, keep, 1'b1, last, err, m_tready});
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard: each accepted timestamp must match the oldest expected record.
  always @(negedge clk) begin
    logic [111:0] exp_item;
    if (rst && m_ts_valid && m_ts_ready) begin
      if (exp_q.size() > 0) exp_item = exp_q.pop_front();
      else exp_item = {112{1'bx}};
      check("ts_record", {m_ts_tag, m_ts}, exp_item);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0001, 48'd5,  32'd100,         16'h0000, 48'd5,  32'd120};
    vecs[1] = '{1'b1, 16'h0002, 48'd5,  32'd999_999_990, 16'h0000, 48'd6,  32'd10};
    vecs[2] = '{1'b1, 16'h0003, 48'd0,  32'd999_999_990, 16'hABCD, 48'd1,  32'd10};
    vecs[3] = '{1'b1, 16'h0004, 48'hFFFF_FFFF_FFFF, 32'd999_999_999, 16'h0007, 48'd0, 32'd19};
    vecs[4] = '{1'b1, 16'h0005, 48'd7,  32'd999_999_979, 16'h0001, 48'd7,  32'd999_999_999};
    vecs[5] = '{1'b0, 16'h0006, 48'd9,  32'd50,          16'h0000, 48'd9,  32'd70};
    vecs[6] = '{1'b1, 16'h0007, 48'd7,  32'd999_999_980, 16'h0002, 48'd8,  32'd0};

    // Reset state
    repeat (3) tick();
    check("rst_ts_valid", m_ts_valid, 1'b0);
    check("rst_ts", m_ts, 96'd0);
    check("rst_ts_tag", m_ts_tag, 16'd0);
    check("rst_drop", drop_a, 16'd0);
    check("rst_b_valid", b_ts_valid, 1'b0);
    rst = 1'b1;
    tick();

    // Three-beat frame, latency and hold-while-stalled
    m_ts_ready = 1'b0;
    exp_q.push_back({16'h1234, tod(48'd5, 32'd120, 16'd0)});
    drive_beat(64'h0011_2233_4455_6677, 8'hFF, 1'b0, 1'b1, 16'h1234, 1'b0, tod(48'd5, 32'd100, 16'd0));
    check("lat_n1_valid", m_ts_valid, 1'b0);
    drive_beat(64'h8899_AABB_CCDD_EEFF, 8'hFF, 1'b0, 1'b1, 16'hEEEE, 1'b0, tod(48'd5, 32'd300, 16'd0));
    check("lat_n2_valid", m_ts_valid, 1'b1);
    drive_beat(64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1, 1'b0, 16'h0000, 1'b1, tod(48'd5, 32'd400, 16'd0));
    check("hold_tag", m_ts_tag, 16'h1234);
    check("hold_ts", m_ts, tod(48'd5, 32'd120, 16'd0));
    m_ts_ready = 1'b1;
    drain(10);

    // Table of back-to-back single-beat frames
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ts_req)
        exp_q.push_back({vecs[i].tag, tod(vecs[i].exp_sec, vecs[i].exp_ns, vecs[i].fns)});
      drive_beat(64'(i) * 64'h0101_0101_0101_0101, 8'hFF, 1'b1, vecs[i].ts_req, vecs[i].tag,
                 1'b0, tod(vecs[i].sec, vecs[i].ns, vecs[i].fns));
    end
    drain(20);

    // Overflow: six captures into a depth-4 FIFO with the consumer stalled
    m_ts_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back({16'(i), tod(48'd1, 32'(i * 10 + 20), 16'd0)});
      drive_beat(64'(i), 8'hFF, 1'b1, 1'b1, 16'(i), 1'b0, tod(48'd1, 32'(i * 10), 16'd0));
    end
    repeat (2) tick();
    check("ovf_drop", drop_a, 16'd2);
    check("ovf_valid", m_ts_valid, 1'b1);

    // Full FIFO with a pop in the same cycle as the push
    exp_q.push_back({16'h0010, tod(48'd2, 32'd20, 16'd0)});
    drive_beat(64'h10, 8'hFF, 1'b1, 1'b1, 16'h0010, 1'b0, tod(48'd2, 32'd0, 16'd0));
    m_ts_ready = 1'b1;
    tick();
    m_ts_ready = 1'b0;
    check("fullpop_drop", drop_a, 16'd2);
    drive_beat(64'h11, 8'hFF, 1'b1, 1'b1, 16'h0011, 1'b0, tod(48'd3, 32'd0, 16'd0));
    tick();
    check("still_full_drop", drop_a, 16'd3);
    m_ts_ready = 1'b1;
    drain(30);

    // ts_req only on a middle beat, and a frame without ts_req
    drive_beat(64'hA0, 8'hFF, 1'b0, 1'b0, 16'h0070, 1'b0, tod(48'd4, 32'd0, 16'd0));
    drive_beat(64'hA1, 8'hFF, 1'b0, 1'b1, 16'h0077, 1'b0, tod(48'd4, 32'd1, 16'd0));
    drive_beat(64'hA2, 8'hFF, 1'b1, 1'b1, 16'h0078, 1'b0, tod(48'd4, 32'd2, 16'd0));
    drive_beat(64'hA3, 8'hFF, 1'b1, 1'b0, 16'h0079, 1'b0, tod(48'd4, 32'd3, 16'd0));
    repeat (3) tick();
    check("noreq_valid", m_ts_valid, 1'b0);

    // Backpressure reaches the source ready
    m_tready = 1'b0;
    #1;
    check("bp_tready", s_tready, 1'b0);
    m_tready = 1'b1;
    tick();

    // 64-bit format, wrap and plain add
    ptp_b    = 64'hFFFF_FFFF_FFFF_0000;
    b_tuser  = {16'hB0B0, 1'b1, 1'b0};
    b_tlast  = 1'b1;
    b_tvalid = 1'b1;
    tick();
    b_tvalid = 1'b0;
    tick();
    check("b64_valid", b_ts_valid, 1'b1);
    check("b64_wrap_ts", b_ts, 64'h0);
    check("b64_tag", b_ts_tag, 16'hB0B0);
    b_ts_ready = 1'b1;
    ptp_b    = 64'h0000_0001_2345_6789;
    b_tuser  = {16'hB0B1, 1'b1, 1'b0};
    b_tvalid = 1'b1;
    tick();
    b_tvalid = 1'b0;
    b_ts_ready = 1'b0;
    tick();
    check("b64_add_ts", b_ts, 64'h0000_0001_2346_6789);
    check("b64_add_tag", b_ts_tag, 16'hB0B1);

    // Reset mid-frame with two entries buffered
    m_ts_ready = 1'b0;
    drive_beat(64'hC0, 8'hFF, 1'b1, 1'b1, 16'h00C0, 1'b0, tod(48'd8, 32'd0, 16'd0));
    drive_beat(64'hC1, 8'hFF, 1'b1, 1'b1, 16'h00C1, 1'b0, tod(48'd8, 32'd1, 16'd0));
    drive_beat(64'hC2, 8'hFF, 1'b0, 1'b0, 16'h00C2, 1'b0, tod(48'd8, 32'd2, 16'd0));
    tick();
    check("prerst_valid", m_ts_valid, 1'b1);
    rst = 1'b0;
    tick();
    check("midrst_valid", m_ts_valid, 1'b0);
    check("midrst_ts", m_ts, 96'd0);
    check("midrst_tag", m_ts_tag, 16'd0);
    check("midrst_drop", drop_a, 16'd0);
    rst = 1'b1;
    exp_q.push_back({16'h0055, tod(48'd9, 32'd520, 16'd3)});
    drive_beat(64'hD0, 8'hFF, 1'b0, 1'b1, 16'h0055, 1'b0, tod(48'd9, 32'd500, 16'd3));
    drive_beat(64'hD1, 8'hFF, 1'b1, 1'b1, 16'h0066, 1'b0, tod(48'd9, 32'd600, 16'd3));
    m_ts_ready = 1'b1;
    drain(20);
    repeat (2) tick();
    check("final_valid", m_ts_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
